// File: rtl/muxn_pkg.sv
// Shared definitions for the N-channel selector family: FSM state encoding,
// operating-mode constants and a small range-check helper.
package muxn_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // True when a channel index addresses one of the n implemented channels.
    function automatic logic ch_in_range(input int ch, input int n);
        return ch < n;
    endfunction

endpackage

// File: rtl/muxn.sv
// Combinational N-to-1 selector over a flattened W-bit channel bus.
// An out-of-range select produces zero rather than an undefined value.
module muxn #(
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic [N*W-1:0] d,
    input  logic [SW-1:0]  s,
    output logic [W-1:0]   y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k)) begin
                y = d[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/muxn_seq.sv
// Sequenced N-channel selector: manual single-beat capture or a one-shot
// sweep of all channels, presented on a registered valid/ready output.
module muxn_seq
    import muxn_pkg::*;
#(
    parameter int N  = 10,
    parameter int W  = 16,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] d,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic           req,
    input  logic           start,
    input  logic           abort,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           busy,
    output logic           done,
    output logic           sel_err
);

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [SW-1:0] cap_ch;
    logic [W-1:0]  mux_y;
    logic          free;
    logic          capture;
    logic          sel_ok;
    logic          done_nxt;
    logic          sel_err_nxt;

    assign free   = !y_valid || y_ready;
    assign sel_ok = ch_in_range(int'(sel), N);
    assign busy   = (state == ST_SCAN);

    muxn #(
        .N (N),
        .W (W)
    ) u_mux (
        .d (d),
        .s (cap_ch),
        .y (mux_y)
    );

    // Abort takes priority over capture so a sweep stops without one extra beat.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        capture     = 1'b0;
        cap_ch      = sel;
        done_nxt    = 1'b0;
        sel_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode == MODE_SCAN) begin
                    if (start) begin
                        state_nxt = ST_SCAN;
                        ptr_nxt   = '0;
                    end
                end else if (req && free) begin
                    if (sel_ok) begin
                        capture = 1'b1;
                    end else begin
                        sel_err_nxt = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                cap_ch = ptr;
                if (abort) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (free) begin
                    capture = 1'b1;
                    if (ptr == SW'(N - 1)) begin
                        state_nxt = ST_IDLE;
                        ptr_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        ptr_nxt = ptr + SW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // y/y_ch only change on a capture, so a stalled beat stays put even if d moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            y       <= '0;
            y_ch    <= '0;
            y_valid <= 1'b0;
            done    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            done    <= done_nxt;
            sel_err <= sel_err_nxt;
            if (capture) begin
                y       <= mux_y;
                y_ch    <= cap_ch;
                y_valid <= 1'b1;
            end else if (free) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxn_seq.sv
// Scoreboard bench for muxn_seq: expected beats are queued as stimulus is
// driven and popped as the DUT hands them over.
module tb_muxn_seq;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [W-1:0]  data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] d;
    logic           mode;
    logic [SW-1:0]  sel;
    logic           req;
    logic           start;
    logic           abort;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_ch;
    logic           y_valid;
    logic           y_ready;
    logic           busy;
    logic           done;
    logic           sel_err;

    logic [W-1:0] dval [N] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                               16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

    beat_t sb_q [$];
    int    vectors     = 0;
    int    miscompares = 0;

    muxn_seq #(
        .N (N),
        .W (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .mode    (mode),
        .sel     (sel),
        .req     (req),
        .start   (start),
        .abort   (abort),
        .y       (y),
        .y_ch    (y_ch),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy),
        .done    (done),
        .sel_err (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        beat_t b;
        for (int k = 0; k < N; k++) begin
            b.ch   = SW'(k);
            b.data = dval[k];
            sb_q.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (y !== '0 || y_ch !== '0 || y_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || sel_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: y=%h ch=%0d v=%b busy=%b done=%b err=%b, want all 0",
                     y, y_ch, y_valid, busy, done, sel_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_manual();
        beat_t b;
        beat_t expb;
        mode    = 1'b0;
        y_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            sel    = SW'(k);
            req    = 1'b1;
            b.ch   = SW'(k);
            b.data = dval[k];
            sb_q.push_back(b);
            step();
            req = 1'b0;
            vectors++;
            if (y_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL manual_valid sel=%0d: got %b, want 1", k, y_valid);
            end else begin
                expb = sb_q.pop_front();
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch) begin
                    miscompares++;
                    $display("[TB] FAIL manual_beat: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, expb.data, expb.ch);
                end
            end
            step();
            vectors++;
            if (y_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL manual_release sel=%0d: y_valid=%b, want 0", k, y_valid);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_out_of_range();
        mode = 1'b0;
        sel  = SW'(12);
        req  = 1'b1;
        step();
        req = 1'b0;
        vectors++;
        if (sel_err !== 1'b1 || y_valid !== 1'b0 || y !== 16'h0004) begin
            miscompares++;
            $display("[TB] FAIL oor_pulse: err=%b v=%b y=%h, want err=1 v=0 y=0004",
                     sel_err, y_valid, y);
        end
        step();
        vectors++;
        if (sel_err !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL oor_single: err=%b v=%b, want 0 0", sel_err, y_valid);
        end
    endtask

    task automatic test_scan();
        beat_t expb;
        logic  exp_done;
        int    cyc;
        int    busy_cycles;
        mode    = 1'b1;
        y_ready = 1'b1;
        start   = 1'b1;
        push_sweep();
        step();
        start       = 1'b0;
        busy_cycles = busy ? 1 : 0;
        vectors++;
        if (y_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL scan_latency: y_valid=%b right after start, want 0", y_valid);
        end
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 40) begin
            step();
            cyc++;
            if (busy) busy_cycles++;
            if (y_valid && y_ready) begin
                expb     = sb_q.pop_front();
                exp_done = (expb.ch == SW'(N - 1));
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch || done !== exp_done) begin
                    miscompares++;
                    $display("[TB] FAIL scan_beat: got %h/ch%0d done=%b, want %h/ch%0d done=%b",
                             y, y_ch, done, expb.data, expb.ch, exp_done);
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0 || cyc != N) begin
            miscompares++;
            $display("[TB] FAIL scan_count: %0d left after %0d cycles, want 0 after %0d",
                     sb_q.size(), cyc, N);
        end
        sb_q.delete();
        vectors++;
        if (busy_cycles != N) begin
            miscompares++;
            $display("[TB] FAIL scan_busy: busy for %0d cycles, want %0d", busy_cycles, N);
        end
        step();
        vectors++;
        if (y_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL scan_end: v=%b done=%b busy=%b, want 0 0 0", y_valid, done, busy);
        end
    endtask

    task automatic test_backpressure();
        beat_t expb;
        int    cyc;
        mode    = 1'b1;
        y_ready = 1'b1;
        start   = 1'b1;
        push_sweep();
        step();
        start = 1'b0;
        cyc   = 0;
        while (sb_q.size() != 0 && cyc < 60) begin
            step();
            cyc++;
            y_ready = !(cyc >= 3 && cyc <= 6);
            if (cyc == 3) d[2*W +: W] = 16'hDEAD;
            if (cyc == 7) d[2*W +: W] = dval[2];
            if (y_valid && y_ready) begin
                expb = sb_q.pop_front();
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch) begin
                    miscompares++;
                    $display("[TB] FAIL bp_beat: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, expb.data, expb.ch);
                end
            end else if (y_valid) begin
                vectors++;
                if (y !== sb_q[0].data || y_ch !== sb_q[0].ch) begin
                    miscompares++;
                    $display("[TB] FAIL bp_stall: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, sb_q[0].data, sb_q[0].ch);
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: %0d beats missing, want 0", sb_q.size());
        end
        sb_q.delete();
        y_ready = 1'b1;
        step();
        vectors++;
        if (y_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_extra: v=%b busy=%b, want 0 0", y_valid, busy);
        end
    endtask

    task automatic test_abort();
        beat_t expb;
        int    cyc;
        logic  hit;
        mode    = 1'b0;
        req     = 1'b0;
        y_ready = 1'b1;
        abort   = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_idle: done=%b busy=%b, want 0 0", done, busy);
        end
        mode  = 1'b1;
        start = 1'b1;
        push_sweep();
        step();
        start = 1'b0;
        cyc   = 0;
        hit   = 1'b0;
        while (!hit && cyc < 40) begin
            step();
            cyc++;
            if (y_valid) begin
                expb = sb_q.pop_front();
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch) begin
                    miscompares++;
                    $display("[TB] FAIL abort_pre: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, expb.data, expb.ch);
                end
                if (expb.ch == SW'(3)) begin
                    abort = 1'b1;
                    hit   = 1'b1;
                end
            end
        end
        sb_q.delete();
        step();
        abort = 1'b0;
        vectors++;
        if (!hit || done !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_stop: hit=%b done=%b busy=%b v=%b, want 1 1 0 0",
                     hit, done, busy, y_valid);
        end
        step();
        vectors++;
        if (done !== 1'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_ch4: done=%b v=%b ch=%0d, want 0 0", done, y_valid, y_ch);
        end
        start = 1'b1;
        push_sweep();
        step();
        start = 1'b0;
        cyc   = 0;
        while (sb_q.size() != 0 && cyc < 40) begin
            step();
            cyc++;
            if (y_valid) begin
                expb = sb_q.pop_front();
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch) begin
                    miscompares++;
                    $display("[TB] FAIL abort_restart: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, expb.data, expb.ch);
                end
            end
        end
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_restart_timeout: %0d beats missing, want 0", sb_q.size());
        end
        sb_q.delete();
        step();
    endtask

    task automatic test_async_reset();
        beat_t expb;
        beat_t b;
        int    cyc;
        logic  hit;
        mode    = 1'b1;
        y_ready = 1'b1;
        start   = 1'b1;
        push_sweep();
        step();
        start = 1'b0;
        cyc   = 0;
        hit   = 1'b0;
        while (!hit && cyc < 40) begin
            step();
            cyc++;
            if (y_valid && y_ch == SW'(6)) begin
                y_ready = 1'b0;
                hit     = 1'b1;
            end else if (y_valid) begin
                expb = sb_q.pop_front();
                vectors++;
                if (y !== expb.data || y_ch !== expb.ch) begin
                    miscompares++;
                    $display("[TB] FAIL rst_pre: got %h/ch%0d, want %h/ch%0d",
                             y, y_ch, expb.data, expb.ch);
                end
            end
        end
        step();
        vectors++;
        if (!hit || y_valid !== 1'b1 || y !== 16'h0001 || y_ch !== SW'(6) || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_stall: v=%b y=%h ch=%0d busy=%b, want 1 0001 ch6 1",
                     y_valid, y, y_ch, busy);
        end
        #2 rst = 1'b1;
        #1;
        sb_q.delete();
        vectors++;
        if (y_valid !== 1'b0 || busy !== 1'b0 || y !== '0 || y_ch !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: v=%b busy=%b y=%h ch=%0d done=%b, want all 0",
                     y_valid, busy, y, y_ch, done);
        end
        #2 rst = 1'b0;
        mode    = 1'b0;
        y_ready = 1'b1;
        sel     = SW'(4);
        req     = 1'b1;
        b.ch    = SW'(4);
        b.data  = dval[4];
        sb_q.push_back(b);
        step();
        req = 1'b0;
        vectors++;
        if (y_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_after_valid: y_valid=%b, want 1", y_valid);
        end else begin
            expb = sb_q.pop_front();
            vectors++;
            if (y !== expb.data || y_ch !== expb.ch) begin
                miscompares++;
                $display("[TB] FAIL rst_after_beat: got %h/ch%0d, want %h/ch%0d",
                         y, y_ch, expb.data, expb.ch);
            end
        end
        sb_q.delete();
        step();
    endtask

    initial begin
        rst     = 1'b1;
        mode    = 1'b0;
        sel     = '0;
        req     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        y_ready = 1'b1;
        for (int k = 0; k < N; k++) d[k*W +: W] = dval[k];
        test_reset();
        test_manual();
        test_out_of_range();
        test_scan();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/muxn_seq.md
Name: muxn_seq

Overview:
- Parametrised N-channel, W-bit selector with a registered output. It generalises the 10x16 combinational mux.
- Two modes:
  - Manual: one beat from the channel on `sel`.
  - Scan: an automatic single sweep of channels 0..N-1.
- The output uses a valid/ready handshake with backpressure and a channel tag on every beat.
- It sits between parallel data sources and a single serial consumer, such as a register-readout or debug stream.

Parameters:
- N, default 10, number of input channels (must be >= 2).
- W, default 16, data width per channel.
- SW, default $clog2(N), select/tag width. Derived; must not be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d  input  N*W  flattened channel data; channel k is d[k*W +: W].
- mode  input  1  0 = manual, 1 = scan; sampled only in IDLE.
- sel  input  SW  manual-mode channel select.
- req  input  1  manual-mode capture request, level.
- start  input  1  scan-mode sweep start, one-cycle pulse.
- abort  input  1  terminates a sweep in progress.
- y  output  W  registered output data.
- y_ch  output  SW  channel index of the data in y.
- y_valid  output  1  y/y_ch hold a beat.
- y_ready  input  1  consumer accepts the beat.
- busy  output  1  a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes or aborts.
- sel_err  output  1  one-cycle pulse on a manual request with sel >= N.

Behaviour:
- Reset values: y=0, y_ch=0, y_valid=0, busy=0, done=0, sel_err=0, state=IDLE, scan pointer ptr=0.
- Slot free: free = !y_valid || y_ready. A capture may happen only on a cycle where free=1.
- Capture: on a cycle with free=1 and a capture condition, y<=d[ch], y_ch<=ch and y_valid<=1 at the next edge. Latency is 1 cycle from condition to y_valid.
- Release: on free=1 with no capture, y_valid<=0 and y/y_ch hold their values.
- Backpressure: while y_valid && !y_ready, y and y_ch stay stable and no capture occurs.
- FSM states: IDLE, SCAN.
- IDLE, mode=0:
  - Capture condition is req && sel<N, with ch=sel.
  - req && sel>=N with free=1: no capture; sel_err=1 for one cycle.
  - req may stay high; one beat is captured per free cycle.
- IDLE, mode=1: start=1 -> SCAN, ptr=0, busy=1 next cycle. req is ignored.
- SCAN:
  - Capture condition is always true, with ch=ptr.
  - Each capture increments ptr.
  - The capture with ptr=N-1 moves to IDLE with ptr=0 and busy=0, and pulses done. That beat still presents normally.
- Inputs ignored while in SCAN: mode, sel, req and start.
- abort in SCAN: next state is IDLE, ptr=0 and done pulses.
  - No capture occurs on the abort cycle, even if the slot is free.
  - A beat already in y remains valid until accepted.
  - abort in IDLE has no effect.
- No wrap-around: one sweep is exactly N beats (channels 0..N-1, in order) unless aborted.
- The d inputs are sampled at capture time. Changing d while a beat is stalled does not alter y.
- rst asserted mid-sweep or mid-stall: all outputs return immediately to their reset values; a pending beat is dropped.

Decomposition:
- Shared package muxn_pkg:
  - State encoding: ST_IDLE=1'b0, ST_SCAN=1'b1.
  - Mode constants: MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
- One combinational sub-module, muxn #(N,W): ports d, s, y. It outputs 0 for out-of-range s and replaces the fixed 10-input mux in new designs.

Test Plan (N=10, W=16; d0..d9 = 0x000A,0x000B,0x000C,0x000D,0x000E,0x000F,0x0001,0x0002,0x0003,0x0004):
1. Manual: mode=0, y_ready=1, req=1 for one cycle per sel=0..9 -> the beat after each request shows y=d[sel] and y_ch=sel (sel=5 -> 0x000F, sel=9 -> 0x0004); y_valid drops the cycle after req goes low.
2. Out of range: mode=0, sel=12, req=1 for 1 cycle -> sel_err pulses once; y_valid stays 0; y holds its previous value.
3. Scan with no backpressure: mode=1, start pulse, y_ready=1 -> 10 consecutive beats 0x000A..0x0004 with y_ch 0..9; busy high for 10 cycles; done coincides with the ch=9 capture.
4. Backpressure: scan with y_ready low for cycles 3-6 -> y holds 0x000C/ch2 stable; no beat is lost or duplicated; total beats = 10, in order.
5. Abort: start a scan, assert abort after the beat with y_ch=3 -> no ch4 beat; done pulses; busy=0; a following start restarts at ch0.
6. Async reset: assert rst mid-sweep while y is stalled at ch6 -> y_valid, busy and y drop to 0 immediately, without a clock edge; after release, IDLE accepts a manual request.
